s2p_frame_ctrl: RTL and testbench

Frame controller for the serial-to-parallel stage of the ConvCode datapath. It accepts a handshaked serial bit stream, groups the bits into WIDTH-bit symbols, and delivers exactly FRAME_LEN symbols per frame on a valid/ready output. Frames are delimited with start/end-of-frame flags. The block sits between the bit source and the encoder/decoder symbol input, and it owns frame start, back-pressure, abort and completion signalling.

---
 rtl/s2p_frame_ctrl_if.sv | 24 ++
 rtl/s2p_frame_ctrl.sv | 117 +++++++++++
 tb/tb_s2p_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/s2p_frame_ctrl_if.sv
// Bit-stream input and symbol-stream output of the serial-to-parallel frame controller.
// The master side feeds bits and consumes symbols; the slave side is the controller.
interface s2p_frame_ctrl_if #(
  parameter int WIDTH = 2
);
  logic             in_valid_sig;
  logic             in_ready_sig;
  logic             serial_sig;
  logic             out_valid_sig;
  logic             out_ready_sig;
  logic [WIDTH-1:0] parallel_sig;
  logic             sof_sig;
  logic             eof_sig;

  modport master (
    output in_valid_sig, serial_sig, out_ready_sig,
    input  in_ready_sig, out_valid_sig, parallel_sig, sof_sig, eof_sig
  );

  modport slave (
    input  in_valid_sig, serial_sig, out_ready_sig,
    output in_ready_sig, out_valid_sig, parallel_sig, sof_sig, eof_sig
  );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Groups a handshaked serial bit stream into WIDTH-bit symbols (first bit = MSB) and
// emits FRAME_LEN symbols per frame with sof/eof flags, abort and a done pulse.
module s2p_frame_ctrl #(
  parameter int WIDTH     = 2,
  parameter int FRAME_LEN = 16,
  parameter int CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic                  clk_sig,
  input  logic                  reset_sig,
  input  logic                  start_sig,
  input  logic                  abort_sig,
  s2p_frame_ctrl_if.slave       bus,
  output logic                  busy_sig,
  output logic                  done_sig,
  output logic [CW-1:0]         sym_count_sig
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_SYM = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    sym_q, sym_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk_sig) begin
    if (!reset_sig) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      par_q     <= '0;
      bit_cnt_q <= '0;
      sym_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      sym_q     <= sym_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    sym_d     = sym_q;
    done_d    = 1'b0;
    shifted   = {shreg_q[WIDTH-2:0], bus.serial_sig};

    // Abort beats every other event, including the final output handshake.
    if (abort_sig) begin
      state_d   = IDLE;
      shreg_d   = '0;
      par_d     = '0;
      bit_cnt_d = '0;
      sym_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_sig) begin
            state_d   = COLLECT;
            shreg_d   = '0;
            bit_cnt_d = '0;
            sym_d     = '0;
          end
        end
        COLLECT: begin
          if (bus.in_valid_sig) begin
            shreg_d = shifted;
            if (bit_cnt_q == LAST_BIT) begin
              par_d     = shifted;
              bit_cnt_d = '0;
              state_d   = OUTPUT;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready_sig) begin
            if (sym_q == LAST_SYM) begin
              state_d = IDLE;
              sym_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = COLLECT;
              sym_d   = sym_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Every output is decoded from registered state only.
  assign bus.in_ready_sig  = (state_q == COLLECT);
  assign bus.out_valid_sig = (state_q == OUTPUT);
  assign bus.parallel_sig  = par_q;
  assign bus.sof_sig       = (state_q == OUTPUT) && (sym_q == '0);
  assign bus.eof_sig       = (state_q == OUTPUT) && (sym_q == LAST_SYM);
  assign busy_sig          = (state_q != IDLE);
  assign done_sig          = done_q;
  assign sym_count_sig     = sym_q;
endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: WIDTH=2/FRAME_LEN=4 instance for the main scenarios
// and a WIDTH=4/FRAME_LEN=1 instance for the single-symbol frame.
module tb_s2p_frame_ctrl;
  logic       clk_sig = 1'b0;
  logic       reset_sig;
  logic       start_a, abort_a, start_b, abort_b;
  logic       busy_a, done_a, busy_b, done_b;
  logic [1:0] sym_a;
  logic [0:0] sym_b;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] nom_sym [4] = '{2'b10, 2'b11, 2'b00, 2'b10};

  s2p_frame_ctrl_if #(.WIDTH(2)) ifa ();
  s2p_frame_ctrl_if #(.WIDTH(4)) ifb ();

  s2p_frame_ctrl #(.WIDTH(2), .FRAME_LEN(4)) dut_a (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .start_sig(start_a), .abort_sig(abort_a),
    .bus(ifa), .busy_sig(busy_a), .done_sig(done_a), .sym_count_sig(sym_a)
  );

  s2p_frame_ctrl #(.WIDTH(4), .FRAME_LEN(1)) dut_b (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .start_sig(start_b), .abort_sig(abort_b),
    .bus(ifb), .busy_sig(busy_b), .done_sig(done_b), .sym_count_sig(sym_b)
  );

  always #5 clk_sig = ~clk_sig;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sig);
    #1;
  endtask

  // Drives one 2-bit symbol MSB first, with 'gap' idle cycles before each bit.
  task automatic send_a(input logic [1:0] s, input int gap);
    for (int i = 1; i >= 0; i--) begin
      ifa.in_valid_sig = 1'b0;
      ifa.serial_sig   = ~s[i];
      repeat (gap) tick();
      ifa.in_valid_sig = 1'b1;
      ifa.serial_sig   = s[i];
      tick();
    end
    ifa.in_valid_sig = 1'b0;
  endtask

  task automatic hs_a();
    ifa.out_ready_sig = 1'b1;
    tick();
    ifa.out_ready_sig = 1'b0;
  endtask

  task automatic test_reset();
    reset_sig = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) tick();
    checks++; if (ifa.in_ready_sig !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", ifa.in_ready_sig); end
    checks++; if (ifa.out_valid_sig !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ifa.out_valid_sig); end
    checks++; if ({ifa.sof_sig, ifa.eof_sig} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {ifa.sof_sig, ifa.eof_sig}); end
    checks++; if ({busy_a, done_a} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy_a, done_a}); end
    checks++; if (ifa.parallel_sig !== 2'b00) begin errors++; $display("FAIL reset_parallel: got %b expected 00", ifa.parallel_sig); end
    checks++; if (sym_a !== 2'd0) begin errors++; $display("FAIL reset_sym_count: got %0d expected 0", sym_a); end
    checks++; if ({busy_b, ifb.out_valid_sig, ifb.parallel_sig} !== 6'b0) begin errors++; $display("FAIL reset_b: got %b expected 000000", {busy_b, ifb.out_valid_sig, ifb.parallel_sig}); end
    start_a = 1'b0;
    start_b = 1'b0;
    reset_sig = 1'b1;
    tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy got %b expected 0", busy_a); end
    $display("reset: done");
  endtask

  task automatic test_nominal();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if ({busy_a, ifa.in_ready_sig} !== 2'b11) begin errors++; $display("FAIL nominal_start: busy/in_ready got %b expected 11", {busy_a, ifa.in_ready_sig}); end
    for (int s = 0; s < 4; s++) begin
      send_a(nom_sym[s], 0);
      $display("nominal: symbol %0d parallel=%b sof=%b eof=%b", sym_a, ifa.parallel_sig, ifa.sof_sig, ifa.eof_sig);
      checks++; if (ifa.out_valid_sig !== 1'b1) begin errors++; $display("FAIL nominal_out_valid[%0d]: got %b expected 1", s, ifa.out_valid_sig); end
      checks++; if (ifa.parallel_sig !== nom_sym[s]) begin errors++; $display("FAIL nominal_parallel[%0d]: got %b expected %b", s, ifa.parallel_sig, nom_sym[s]); end
      checks++; if (sym_a !== 2'(s)) begin errors++; $display("FAIL nominal_sym_count[%0d]: got %0d expected %0d", s, sym_a, s); end
      checks++; if (ifa.sof_sig !== (s == 0)) begin errors++; $display("FAIL nominal_sof[%0d]: got %b expected %b", s, ifa.sof_sig, (s == 0)); end
      checks++; if (ifa.eof_sig !== (s == 3)) begin errors++; $display("FAIL nominal_eof[%0d]: got %b expected %b", s, ifa.eof_sig, (s == 3)); end
      checks++; if (ifa.in_ready_sig !== 1'b0) begin errors++; $display("FAIL nominal_in_ready_out[%0d]: got %b expected 0", s, ifa.in_ready_sig); end
      hs_a();
      if (s < 3) begin
        checks++; if ({ifa.in_ready_sig, done_a} !== 2'b10) begin errors++; $display("FAIL nominal_after_hs[%0d]: in_ready/done got %b expected 10", s, {ifa.in_ready_sig, done_a}); end
      end else begin
        checks++; if ({done_a, busy_a} !== 2'b10) begin errors++; $display("FAIL nominal_done: done/busy got %b expected 10", {done_a, busy_a}); end
      end
    end
    tick();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL nominal_done_pulse: got %b expected 0", done_a); end
  endtask

  task automatic test_back_pressure();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_a(2'b10, 0);
    hs_a();
    send_a(2'b11, 0);
    // Offer the next symbol's first bit during the hold; it must not be consumed.
    ifa.in_valid_sig = 1'b1;
    ifa.serial_sig   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({ifa.out_valid_sig, ifa.in_ready_sig, ifa.parallel_sig, sym_a} !== 6'b101101) begin
        errors++; $display("FAIL bp_hold[%0d]: valid/ready/par/cnt got %b expected 101101", c, {ifa.out_valid_sig, ifa.in_ready_sig, ifa.parallel_sig, sym_a});
      end
      tick();
    end
    ifa.in_valid_sig = 1'b0;
    hs_a();
    send_a(2'b01, 1);
    $display("back_pressure: symbol %0d parallel=%b", sym_a, ifa.parallel_sig);
    checks++; if ({ifa.out_valid_sig, ifa.parallel_sig, sym_a} !== 5'b10110) begin errors++; $display("FAIL bp_gap1: valid/par/cnt got %b expected 10110", {ifa.out_valid_sig, ifa.parallel_sig, sym_a}); end
    hs_a();
    send_a(2'b10, 3);
    $display("back_pressure: symbol %0d parallel=%b", sym_a, ifa.parallel_sig);
    checks++; if ({ifa.out_valid_sig, ifa.parallel_sig, sym_a, ifa.eof_sig} !== 6'b110111) begin errors++; $display("FAIL bp_gap3: valid/par/cnt/eof got %b expected 110111", {ifa.out_valid_sig, ifa.parallel_sig, sym_a, ifa.eof_sig}); end
    hs_a();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", done_a); end
    tick();
  endtask

  task automatic test_abort();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_a(2'b10, 0);
    hs_a();
    send_a(2'b11, 0);
    hs_a();
    ifa.in_valid_sig = 1'b1;
    ifa.serial_sig   = 1'b0;
    tick();
    ifa.in_valid_sig = 1'b0;
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++; if ({busy_a, ifa.in_ready_sig, ifa.out_valid_sig, sym_a, done_a} !== 6'b0) begin errors++; $display("FAIL abort_idle: busy/rdy/vld/cnt/done got %b expected 000000", {busy_a, ifa.in_ready_sig, ifa.out_valid_sig, sym_a, done_a}); end
    tick();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done_a); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_a(2'b01, 0);
    $display("abort: fresh frame symbol %0d parallel=%b sof=%b", sym_a, ifa.parallel_sig, ifa.sof_sig);
    checks++; if ({ifa.out_valid_sig, ifa.sof_sig, ifa.parallel_sig, sym_a} !== 6'b110100) begin errors++; $display("FAIL abort_restart: vld/sof/par/cnt got %b expected 110100", {ifa.out_valid_sig, ifa.sof_sig, ifa.parallel_sig, sym_a}); end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++; if ({busy_a, ifa.out_valid_sig} !== 2'b00) begin errors++; $display("FAIL abort_in_output: busy/vld got %b expected 00", {busy_a, ifa.out_valid_sig}); end
  endtask

  task automatic test_priority();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send_a(2'b10, 0);
    hs_a();
    ifa.in_valid_sig = 1'b1;
    ifa.serial_sig   = 1'b1;
    tick();
    ifa.in_valid_sig = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ifa.in_valid_sig = 1'b1;
    ifa.serial_sig   = 1'b1;
    tick();
    ifa.in_valid_sig = 1'b0;
    checks++; if ({ifa.out_valid_sig, ifa.parallel_sig, sym_a} !== 5'b11101) begin errors++; $display("FAIL prio_start_in_collect: vld/par/cnt got %b expected 11101", {ifa.out_valid_sig, ifa.parallel_sig, sym_a}); end
    hs_a();
    send_a(2'b00, 0);
    hs_a();
    send_a(2'b01, 0);
    checks++; if ({ifa.eof_sig, sym_a} !== 3'b111) begin errors++; $display("FAIL prio_last_symbol: eof/cnt got %b expected 111", {ifa.eof_sig, sym_a}); end
    ifa.out_ready_sig = 1'b1;
    abort_a = 1'b1;
    tick();
    ifa.out_ready_sig = 1'b0;
    abort_a = 1'b0;
    checks++; if ({busy_a, done_a} !== 2'b00) begin errors++; $display("FAIL prio_abort_vs_hs: busy/done got %b expected 00", {busy_a, done_a}); end
    tick();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL prio_abort_no_done: got %b expected 0", done_a); end

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int s = 0; s < 4; s++) begin
      send_a(2'(s), 0);
      if (s < 3) hs_a();
    end
    hs_a();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL prio_done_cycle: got %b expected 1", done_a); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if ({busy_a, ifa.in_ready_sig, done_a} !== 3'b110) begin errors++; $display("FAIL prio_start_on_done: busy/rdy/done got %b expected 110", {busy_a, ifa.in_ready_sig, done_a}); end
    send_a(2'b11, 0);
    $display("priority: restarted frame symbol %0d parallel=%b sof=%b", sym_a, ifa.parallel_sig, ifa.sof_sig);
    checks++; if ({ifa.sof_sig, ifa.parallel_sig, sym_a} !== 5'b11100) begin errors++; $display("FAIL prio_restart_sof: sof/par/cnt got %b expected 11100", {ifa.sof_sig, ifa.parallel_sig, sym_a}); end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
  endtask

  task automatic test_edge_params();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++; if (ifb.in_ready_sig !== 1'b1) begin errors++; $display("FAIL edge_in_ready: got %b expected 1", ifb.in_ready_sig); end
    ifb.in_valid_sig = 1'b1;
    ifb.serial_sig = 1'b1; tick();
    ifb.serial_sig = 1'b1; tick();
    ifb.serial_sig = 1'b0; tick();
    ifb.serial_sig = 1'b1; tick();
    ifb.in_valid_sig = 1'b0;
    $display("edge: symbol %0d parallel=%b sof=%b eof=%b", sym_b, ifb.parallel_sig, ifb.sof_sig, ifb.eof_sig);
    checks++; if (ifb.parallel_sig !== 4'b1101) begin errors++; $display("FAIL edge_parallel: got %b expected 1101", ifb.parallel_sig); end
    checks++; if ({ifb.out_valid_sig, ifb.sof_sig, ifb.eof_sig, sym_b} !== 4'b1110) begin errors++; $display("FAIL edge_flags: vld/sof/eof/cnt got %b expected 1110", {ifb.out_valid_sig, ifb.sof_sig, ifb.eof_sig, sym_b}); end
    ifb.out_ready_sig = 1'b1;
    tick();
    ifb.out_ready_sig = 1'b0;
    checks++; if ({done_b, busy_b, ifb.out_valid_sig} !== 3'b100) begin errors++; $display("FAIL edge_done: done/busy/vld got %b expected 100", {done_b, busy_b, ifb.out_valid_sig}); end
  endtask

  initial begin
    reset_sig = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    ifa.in_valid_sig = 1'b0; ifa.serial_sig = 1'b0; ifa.out_ready_sig = 1'b0;
    ifb.in_valid_sig = 1'b0; ifb.serial_sig = 1'b0; ifb.out_ready_sig = 1'b0;
    test_reset();
    test_nominal();
    test_back_pressure();
    test_abort();
    test_priority();
    test_edge_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
